icache_fetch: RTL
=================

Name: icache_fetch

Overview:
- Direct-mapped, one-word-per-line instruction cache between the IF stage and the memory controller's instruction read port.
- Hits return the instruction one cycle after the request.
- Misses run a single read through the controller's inst_re / inst_raddr / inst_rdata / inst_rbusy handshake, fill the line, then return the word.
- Flush invalidates every line so the cache is coherent after a program load or fence.

Parameters:
- IDX_W, 7, index bits; the cache holds 2^IDX_W lines.
- ADDR_W, 18, significant byte-address bits; higher bits are ignored.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  chip ready; when low, all state and outputs hold
- flush  in  1  invalidate all lines and drop any in-flight response
- if_req  in  1  fetch request, sampled while if_stall=0
- if_addr  in  32  fetch byte address, word-aligned
- if_inst  out  32  fetched instruction
- if_valid  out  1  one-cycle pulse; if_inst is valid
- if_stall  out  1  cache busy; requests are ignored
- mc_re  out  1  read request to the memory controller
- mc_addr  out  32  read address to the memory controller
- mc_rdata  in  32  read data from the memory controller
- mc_busy  in  1  controller instruction-read busy

Behaviour:
- Reset (synchronous, rst=1 at a clk edge), applied from any state:
  - valid[] cleared; state=IDLE.
  - if_inst=0, if_valid=0, if_stall=0, mc_re=0, mc_addr=0.
  - Any outstanding miss is abandoned.
- rdy=0: no state change and outputs hold. rdy is checked after rst.
- Address split:
  - index = if_addr[IDX_W+1:2]
  - tag = if_addr[ADDR_W-1:IDX_W+2]
  - Bits [1:0] and above ADDR_W-1 are ignored.
- Storage: data[2^IDX_W] x 32, tag[2^IDX_W] x (ADDR_W-2-IDX_W), valid[2^IDX_W] as a flop vector.
- if_valid defaults to 0 every cycle; it is high for exactly one cycle per served request.
- State machine:
  - IDLE, if_req=1, flush=0:
    - Hit (valid[index] and tag match): next cycle if_inst=data[index], if_valid=1, stay in IDLE. Back-to-back hits sustain one instruction per cycle.
    - Miss: latch the address into req_addr, set if_stall=1 and mc_re=1, drive mc_addr={req_addr[31:2],2'b00}, go to REQ.
  - REQ:
    - mc_re and mc_addr held.
    - When mc_busy=1 is sampled: mc_re<=0, go to WAIT.
    - mc_re is never held longer than needed; the controller latches on inst_re level.
  - WAIT:
    - When mc_busy=0 is sampled: go to FILL.
    - Controller data is valid the cycle busy drops.
  - FILL:
    - Write data[idx]=mc_rdata, tag[idx]=req tag, valid[idx]=1.
    - Unless the request was dropped: if_inst=mc_rdata, if_valid=1.
    - if_stall<=0, go to IDLE.
- Miss latency: at least 4 cycles from request to if_valid, plus the controller's busy duration.
- Flush:
  - Clears all valid bits in one cycle.
  - Flush in the same cycle as if_req in IDLE: flush wins and the request is dropped with no response. IF must re-request.
  - Flush during REQ/WAIT/FILL:
    - Sets the drop flag.
    - The memory transaction still completes; mc_re follows the normal rules and the controller is never aborted.
    - The FILL write is suppressed.
    - No if_valid is issued.
    - The cache returns to IDLE with if_stall=0.
- Only one miss is outstanding at a time. if_req/if_addr changes while if_stall=1 are ignored.
- A FILL write and a flush in the same cycle: flush wins and the line stays invalid.
- Index aliasing: a fill overwrites the previous line unconditionally (no replacement policy).

Test Plan:
- Cold miss:
  - Stimulus: reset, then if_req with if_addr=0x00000100; controller model raises busy 1 cycle after mc_re, holds it 10 cycles, returns 0x00A00093.
  - Required: mc_re high until busy is seen; mc_addr=0x100; if_valid with if_inst=0x00A00093; if_stall low afterwards.
- Hit:
  - Stimulus: re-request 0x100.
  - Required: if_valid next cycle, if_inst=0x00A00093, mc_re stays 0.
- Back-to-back hits:
  - Stimulus: 0x100, 0x104, 0x108 after all are filled.
  - Required: three consecutive if_valid pulses and no mc_re.
- Conflict miss:
  - Stimulus: fill 0x100, then request 0x300 (same index with IDX_W=7, different tag), then 0x100 again.
  - Required: both requests after the first fill miss and issue mc_re; each returns its correct data.
- Flush mid-miss:
  - Stimulus: assert flush for 1 cycle while in WAIT.
  - Required: no if_valid; line not written; a later request to the same address misses again.
- Reset and rdy:
  - Stimulus: assert rst during WAIT; separately, hold rdy=0 for 5 cycles during REQ.
  - Required: reset gives all outputs 0, state IDLE, and a previously cached address misses. With rdy=0, mc_re and mc_addr hold unchanged and the sequence resumes when rdy returns.

Source files
------------

// File: rtl/icache_fetch.sv
// Direct-mapped, one-word-per-line instruction cache sitting between the IF stage
// and the memory controller's instruction read port.
module icache_fetch #(
    parameter int IDX_W  = 7,
    parameter int ADDR_W = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        if_stall,
    output logic        mc_re,
    output logic [31:0] mc_addr,
    input  logic [31:0] mc_rdata,
    input  logic        mc_busy
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] FILL = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:2] req_addr_q, req_addr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              drop_q, drop_d;
    logic [31:0]       inst_q, inst_d;
    logic              ivld_q, ivld_d;
    logic              stall_q, stall_d;
    logic              mcre_q, mcre_d;
    logic [31:0]       mcaddr_q, mcaddr_d;
    logic [LINES-1:0]  valid_q, valid_d;

    logic [31:0]       data_mem [LINES];
    logic [TAG_W-1:0]  tag_mem  [LINES];

    logic [IDX_W-1:0]  idx, req_idx;
    logic [TAG_W-1:0]  tag, req_tag;
    logic              hit;
    logic              fill_we;
    logic              unused_addr_bits;

    assign idx     = if_addr[IDX_W+1:2];
    assign tag     = if_addr[ADDR_W-1:IDX_W+2];
    assign req_idx = req_addr_q[IDX_W+1:2];
    assign req_tag = req_addr_q[ADDR_W-1:IDX_W+2];
    assign hit     = valid_q[idx] && (tag_mem[idx] == tag);
    assign unused_addr_bits = ^if_addr[1:0];

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        rdata_d    = rdata_q;
        drop_d     = drop_q;
        inst_d     = inst_q;
        ivld_d     = ivld_q;
        stall_d    = stall_q;
        mcre_d     = mcre_q;
        mcaddr_d   = mcaddr_q;
        valid_d    = valid_q;
        fill_we    = 1'b0;
        if (rdy) begin
            ivld_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (!flush && if_req) begin
                        if (hit) begin
                            inst_d = data_mem[idx];
                            ivld_d = 1'b1;
                        end else begin
                            req_addr_d = if_addr[ADDR_W-1:2];
                            stall_d    = 1'b1;
                            mcre_d     = 1'b1;
                            mcaddr_d   = {if_addr[31:2], 2'b00};
                            drop_d     = 1'b0;
                            state_d    = REQ;
                        end
                    end
                end
                REQ: begin
                    if (mc_busy) begin
                        mcre_d  = 1'b0;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    // Controller data is only guaranteed in the cycle busy falls.
                    if (!mc_busy) begin
                        rdata_d = mc_rdata;
                        state_d = FILL;
                    end
                end
                default: begin
                    if (!drop_q && !flush) begin
                        fill_we          = 1'b1;
                        valid_d[req_idx] = 1'b1;
                        inst_d           = rdata_q;
                        ivld_d           = 1'b1;
                    end
                    drop_d  = 1'b0;
                    stall_d = 1'b0;
                    state_d = IDLE;
                end
            endcase
            if (flush) begin
                valid_d = '0;
                if (state_q == REQ || state_q == WAIT) begin
                    drop_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            drop_q   <= 1'b0;
            inst_q   <= 32'd0;
            ivld_q   <= 1'b0;
            stall_q  <= 1'b0;
            mcre_q   <= 1'b0;
            mcaddr_q <= 32'd0;
            valid_q  <= '0;
        end else begin
            state_q  <= state_d;
            drop_q   <= drop_d;
            inst_q   <= inst_d;
            ivld_q   <= ivld_d;
            stall_q  <= stall_d;
            mcre_q   <= mcre_d;
            mcaddr_q <= mcaddr_d;
            valid_q  <= valid_d;
        end
    end

    // Line storage and the miss address/data carry no reset; valid_q gates their use.
    always_ff @(posedge clk) begin
        req_addr_q <= req_addr_d;
        rdata_q    <= rdata_d;
        if (fill_we && !rst) begin
            data_mem[req_idx] <= rdata_q;
            tag_mem[req_idx]  <= req_tag;
        end
    end

    assign if_inst  = inst_q;
    assign if_valid = ivld_q;
    assign if_stall = stall_q;
    assign mc_re    = mcre_q;
    assign mc_addr  = mcaddr_q;
endmodule
